key_schedule_ctrl: RTL and testbench
====================================

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, 11 round keys (rk0..rk10).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 key_in  input  128  cipher key; word0 = key_in[127:96].
REQ-005 key_valid  input  1  key_in valid; transfer on key_valid && key_ready at a clk edge.
REQ-006 key_ready  output  1  block can accept a new key.
REQ-007 busy  output  1  expansion in progress.
REQ-008 keys_valid  output  1  rk0..rk10 complete and consistent for the last accepted key.
REQ-009 rd_round  input  4  round-key read index, 0..10.
REQ-010 rd_key  output  128  registered round key for rd_round.
REQ-011 rd_err  output  1  registered flag: rd_round > 10 on the previous cycle.

Function
REQ-012 The block SHALL compute one round key per clock, iteratively, using exactly 4 instances of the codebase Sbox byte module on RotWord(w[i-1]).
REQ-013 Storage SHALL be an 11 x 128-bit register array; no other key-wide datapath duplication.
REQ-014 The FSM SHALL have states IDLE, EXPAND, READY; encoding is free.
REQ-015 IDLE: key_ready=1, busy=0, keys_valid=0; on handshake at edge T: rk0<=key_in, rnd<=1, rcon<=8'h01, go EXPAND.
REQ-016 EXPAND: key_ready=0, busy=1, keys_valid=0; each edge: rk[rnd]<=next(rk[rnd-1], rcon), rnd<=rnd+1, rcon<=xtime(rcon) (0x80 -> 0x1b).
REQ-017 next(): w4=w0^SubWord(RotWord(w3))^{rcon,24'h0}; w5=w1^w4; w6=w2^w5; w7=w3^w6.
REQ-018 rk1..rk10 SHALL be written at edges T+1..T+10; at edge T+10 go READY.
REQ-019 READY: key_ready=1, busy=0, keys_valid=1; registers hold indefinitely.
REQ-020 Handshake in READY at edge T SHALL behave as in IDLE: keys_valid=0 from T, rk0 replaced, rk1..rk10 regenerated.
REQ-021 key_valid SHALL be ignored while key_ready=0; no queuing of a rejected key.
REQ-022 Read path: every edge rd_key<=rk[rd_round], rd_err<=0 when rd_round<=10; else rd_key<=0, rd_err<=1; one-cycle latency, reads independent of FSM state.
REQ-023 Reads during EXPAND SHALL return current array content (partially updated); consumers SHALL qualify with keys_valid.
REQ-024 rnd and rcon SHALL never advance outside EXPAND; rnd never exceeds 10 in any written index.

Reset
REQ-025 rst=1 at an edge SHALL set state=IDLE, rnd=0, rcon=8'h01, keys_valid=0, busy=0, rd_key=0, rd_err=0, all rk entries=0; key_ready=1 after the edge.
REQ-026 rst SHALL dominate a simultaneous handshake; the key is not accepted.
REQ-027 rst mid-EXPAND SHALL abort expansion; keys_valid stays 0 until a new key completes.

Verification
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c accepted at T -> busy T..T+9, keys_valid high after T+10; rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 Key all-zero -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-030 key_valid held high through EXPAND with changing key_in -> only key at T used; next accepted only at first READY edge.
REQ-031 rst asserted at T+5, new key 2b7e... at T+7 -> keys_valid low until T+17, then REQ-028 values.
REQ-032 rd_round sweep 0..15 in READY -> rd_key one cycle later matches rk table; 11..15 give rd_key=0, rd_err=1.
REQ-033 Back-to-back: zero key then 2b7e... accepted on first READY edge -> keys_valid drops one cycle after the handshake edge, rises 10 cycles later with REQ-028 values.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands a 128-bit cipher key into
// rk0..rk10 at one round key per clock and serves registered reads.

// Combinational AES S-box: GF(2^8) multiplicative inverse then affine map.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8) (and maps 0 to 0), via an addition chain
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] t;
    t = gmul(gmul(x, x), x);   // x^3
    t = gmul(gmul(t, t), x);   // x^7
    t = gmul(gmul(t, t), x);   // x^15
    t = gmul(gmul(t, t), x);   // x^31
    t = gmul(gmul(t, t), x);   // x^63
    t = gmul(gmul(t, t), x);   // x^127
    return gmul(t, t);         // x^254
  endfunction

  logic [7:0] inv;

  // inverse followed by the FIPS-197 affine transform
  always_comb begin
    inv = ginv(a_i);
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_schedule_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_err
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t        state_q, state_d;
  logic [127:0]  rk_q [0:10];
  logic [3:0]    rnd_q;
  logic [7:0]    rcon_q;
  logic [127:0]  rd_key_q;
  logic          rd_err_q;

  logic          hs;
  logic [127:0]  prev_rk, next_rk, rd_mux;
  logic [31:0]   w0, w1, w2, w3, w4, w5, w6, w7, rot_w, sub_w;

  assign hs = key_valid && key_ready;

  // Previous round key selected by rnd-1 (rnd is 1..10 while expanding)
  always_comb begin
    prev_rk = rk_q[0];
    for (int i = 1; i <= 10; i++)
      if (rnd_q == 4'(i)) prev_rk = rk_q[i-1];
  end

  assign {w0, w1, w2, w3} = prev_rk;
  assign rot_w = {w3[23:0], w3[31:24]};

  // Four byte S-boxes perform SubWord(RotWord(w3)), shared by all rounds
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(rot_w[8*g +: 8]), .s_o(sub_w[8*g +: 8]));
  end

  assign w4 = w0 ^ sub_w ^ {rcon_q, 24'h0};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;
  assign next_rk = {w4, w5, w6, w7};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: a new key may be taken whenever not expanding
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, READY: if (hs) state_d = EXPAND;
      EXPAND:      if (rnd_q == 4'd10) state_d = READY;
      default:     state_d = IDLE;
    endcase
  end

  // FSM outputs, purely state-decoded
  always_comb begin
    key_ready  = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    case (state_q)
      IDLE:    key_ready = 1'b1;
      EXPAND:  busy      = 1'b1;
      READY: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
      end
      default: key_ready = 1'b0;
    endcase
  end

  // Key array, round counter and rcon; only move on a handshake or in EXPAND
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
      rnd_q  <= 4'd0;
      rcon_q <= 8'h01;
    end else if (hs) begin
      rk_q[0] <= key_in;
      rnd_q   <= 4'd1;
      rcon_q  <= 8'h01;
    end else if (state_q == EXPAND) begin
      for (int i = 1; i <= 10; i++)
        if (rnd_q == 4'(i)) rk_q[i] <= next_rk;
      rnd_q  <= rnd_q + 4'd1;
      rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  // Read mux over the array; out-of-range indices resolve to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= 10; i++)
      if (rd_round == 4'(i)) rd_mux = rk_q[i];
  end

  // Registered read port, independent of FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      rd_key_q <= rd_mux;
      rd_err_q <= (rd_round > 4'd10);
    end
  end

  assign rd_key = rd_key_q;
  assign rd_err = rd_err_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: known-answer table, random keys
// against a word-level key-expansion model, and timing corner sequences.
module tb_key_schedule_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready, busy, keys_valid, rd_err;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  int nvec = 0;
  int nfail = 0;

  key_schedule_ctrl dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid),
    .rd_round(rd_round), .rd_key(rd_key), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]   sb [0:255];
  logic [127:0] m_rk [0:10];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // handshake edge happens inside; returns just after edge T
  task automatic load_key(input logic [127:0] k);
    int n;
    n = 0;
    while (!key_ready && n < 50) begin tick(); n++; end
    chk("key_ready_before_load", 128'(key_ready), 128'd1);
    key_in = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_kv(output int n);
    n = 0;
    while (!keys_valid && n < 100) begin tick(); n++; end
  endtask

  task automatic read_rk(input int r, input logic [127:0] exp, input logic err, input string name);
    rd_round = 4'(r);
    tick();
    chk(name, rd_key, exp);
    chk({name, "_err"}, 128'(rd_err), 128'(err));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } kat_t;

  localparam logic [127:0] K2B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    kat_t kat [0:1];
    int n;
    logic [127:0] k, ka, kb, a_rk1;

    kat[0] = '{key: 128'h0,
               rk1:  128'h62636363626363636263636362636363,
               rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    kat[1] = '{key: K2B, rk1: K2B_RK1, rk10: K2B_RK10};

    build_sbox();
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rd_round = 4'd5;
    tick(); tick();
    // reset state
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("rst_rd_key", rd_key, 128'd0);
    chk("rst_rd_err", 128'(rd_err), 128'd0);
    rst = 1'b0;
    read_rk(5, 128'd0, 1'b0, "rst_rk5");

    // reset dominates a simultaneous handshake
    rst = 1'b1; key_valid = 1'b1; key_in = K2B;
    tick();
    rst = 1'b0; key_valid = 1'b0;
    chk("rst_dom_busy", 128'(busy), 128'd0);
    tick();
    chk("rst_dom_busy2", 128'(busy), 128'd0);
    chk("rst_dom_kv", 128'(keys_valid), 128'd0);

    // known-answer table, loaded back-to-back (zero key then 2b7e...)
    for (int v = 0; v < 2; v++) begin
      load_key(kat[v].key);
      chk("hs_kv_drop", 128'(keys_valid), 128'd0);
      chk("hs_busy", 128'(busy), 128'd1);
      chk("hs_key_ready", 128'(key_ready), 128'd0);
      wait_kv(n);
      chk("expand_latency", 128'(n), 128'd10);
      chk("ready_busy", 128'(busy), 128'd0);
      model_expand(kat[v].key);
      chk("model_rk1", m_rk[1], kat[v].rk1);
      chk("model_rk10", m_rk[10], kat[v].rk10);
      read_rk(1, kat[v].rk1, 1'b0, "kat_rk1");
      read_rk(10, kat[v].rk10, 1'b0, "kat_rk10");
    end

    // random keys with full read sweep 0..15
    for (int t = 0; t < 6; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      load_key(k);
      wait_kv(n);
      chk("rand_latency", 128'(n), 128'd10);
      for (int r = 0; r < 16; r++)
        read_rk(r, (r <= 10) ? m_rk[r] : 128'd0, (r > 10), "rand_sweep");
    end

    // key_valid held through EXPAND with changing key_in
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    model_expand(ka);
    a_rk1 = m_rk[1];
    key_in = ka; key_valid = 1'b1;
    tick();                                  // T: accept ka
    for (int c = 1; c <= 9; c++) begin
      key_in = {$urandom, $urandom, $urandom, $urandom};
      chk("hold_busy", 128'(busy), 128'd1);
      tick();
    end
    key_in = kb;
    tick();                                  // T+10: into READY
    chk("hold_ready_kv", 128'(keys_valid), 128'd1);
    rd_round = 4'd1;
    tick();                                  // T+11: accept kb, read old rk1
    key_valid = 1'b0;
    chk("hold_old_rk1", rd_key, a_rk1);
    chk("hold_kv_drop", 128'(keys_valid), 128'd0);
    wait_kv(n);
    chk("hold_latency", 128'(n), 128'd10);
    model_expand(kb);
    read_rk(1, m_rk[1], 1'b0, "hold_new_rk1");
    read_rk(10, m_rk[10], 1'b0, "hold_new_rk10");

    // reset mid-expansion, then 2b7e key two cycles later
    load_key(128'h0);                        // edge T
    for (int c = 1; c <= 4; c++) tick();
    rst = 1'b1;
    tick();                                  // T+5
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_kv", 128'(keys_valid), 128'd0);
    chk("abort_key_ready", 128'(key_ready), 128'd1);
    read_rk(1, 128'd0, 1'b0, "abort_rk1_cleared"); // T+6
    load_key(K2B);                           // T+7
    wait_kv(n);
    chk("abort_latency", 128'(n), 128'd10);
    read_rk(1, K2B_RK1, 1'b0, "abort_rk1");
    read_rk(10, K2B_RK10, 1'b0, "abort_rk10");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
